// File: rtl/af_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy, watermark and error flags.
// DOUT is registered from the next head word, so flags and data see no PUSH/POP combinational path.
module af_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int FULL_WM    = (1 << ADDR_WIDTH) - 4,
  parameter int EMPTY_WM   = 4
) (
  input  logic                  clock0,
  input  logic                  Async_Flush,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  PUSH,
  input  logic                  POP,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic                  Full_Watermark,
  output logic                  Empty_Watermark,
  output logic                  Overrun_Error,
  output logic                  Underrun_Error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_CNT      = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] FULL_WM_CNT  = (ADDR_WIDTH+1)'(FULL_WM);
  localparam logic [ADDR_WIDTH:0] EMPTY_WM_CNT = (ADDR_WIDTH+1)'(EMPTY_WM);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr_next;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_en;
  logic                  rd_en;

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  always_comb begin
    rd_en       = POP && !Empty;
    wr_en       = PUSH && (!Full || rd_en);
    rd_ptr_next = rd_en ? rd_ptr + 1'b1 : rd_ptr;
    count_next  = count;
    if (wr_en && !rd_en) begin
      count_next = count + 1'b1;
    end else if (rd_en && !wr_en) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clock0) begin
    if (wr_en) begin
      mem[wr_ptr] <= DIN;
    end
  end

  // When the next head is the slot being written this edge, forward DIN instead of memory.
  always_ff @(posedge clock0 or posedge Async_Flush) begin
    if (Async_Flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      DOUT           <= '0;
      Overrun_Error  <= 1'b0;
      Underrun_Error <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr         <= rd_ptr_next;
      count          <= count_next;
      Overrun_Error  <= PUSH && !wr_en;
      Underrun_Error <= POP && Empty;
      if (count_next != '0) begin
        if (wr_en && (rd_ptr_next == wr_ptr)) begin
          DOUT <= DIN;
        end else begin
          DOUT <= mem[rd_ptr_next];
        end
      end
    end
  end

  assign Full            = (count == DEPTH_CNT);
  assign Empty           = (count == '0);
  assign Almost_Full     = (count == DEPTH_CNT - 1'b1);
  assign Almost_Empty    = (count == ONE_CNT);
  assign Full_Watermark  = (count >= FULL_WM_CNT);
  assign Empty_Watermark = (count <= EMPTY_WM_CNT);

endmodule

// File: tb/tb_af_fifo.sv
// Scoreboard bench for af_fifo: a queue-based reference model predicts outputs per edge,
// and an independent monitor compares them one time unit after each rising edge.
module tb_af_fifo;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clock0;
  logic          Async_Flush;
  logic [DW-1:0] DIN;
  logic          PUSH;
  logic          POP;
  logic [DW-1:0] DOUT;
  logic          Full, Empty, Almost_Full, Almost_Empty;
  logic          Full_Watermark, Empty_Watermark, Overrun_Error, Underrun_Error;

  typedef struct {
    logic [DW-1:0] dout;
    logic [7:0]    flags;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout;
  int            checks = 0;
  int            errors = 0;

  af_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock0(clock0), .Async_Flush(Async_Flush), .DIN(DIN), .PUSH(PUSH), .POP(POP),
    .DOUT(DOUT), .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full),
    .Almost_Empty(Almost_Empty), .Full_Watermark(Full_Watermark),
    .Empty_Watermark(Empty_Watermark), .Overrun_Error(Overrun_Error),
    .Underrun_Error(Underrun_Error)
  );

  initial clock0 = 1'b0;
  always #5 clock0 = ~clock0;

  function automatic logic [7:0] expFlags(int n, bit ovr, bit und);
    return {n == DEPTH, n == 0, n == DEPTH - 1, n == 1,
            n >= DEPTH - 4, n <= 4, ovr, und};
  endfunction

  function automatic logic [7:0] dutFlags();
    return {Full, Empty, Almost_Full, Almost_Empty,
            Full_Watermark, Empty_Watermark, Overrun_Error, Underrun_Error};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one edge's inputs and record what the FIFO should show after that edge.
  task automatic applyStimulus(input bit push, input bit pop, input logic [DW-1:0] din);
    bit   rd_ok, wr_ok, ovr, und;
    int   n;
    exp_t e;
    @(negedge clock0);
    PUSH = push;
    POP  = pop;
    DIN  = din;
    n     = model_q.size();
    rd_ok = pop && (n != 0);
    wr_ok = push && ((n != DEPTH) || rd_ok);
    ovr   = push && !wr_ok;
    und   = pop && (n == 0);
    if (rd_ok) void'(model_q.pop_front());
    if (wr_ok) model_q.push_back(din);
    if (model_q.size() != 0) model_dout = model_q[0];
    e.dout  = model_dout;
    e.flags = expFlags(model_q.size(), ovr, und);
    exp_q.push_back(e);
  endtask

  task automatic resetFifo();
    @(negedge clock0);
    PUSH        = 1'b0;
    POP         = 1'b0;
    Async_Flush = 1'b1;
    #1;
    model_q.delete();
    model_dout = '0;
    checkOutput("reset_dout", 32'(DOUT), 32'(0));
    checkOutput("reset_flags", 32'(dutFlags()), 32'(expFlags(0, 1'b0, 1'b0)));
    #39;
    Async_Flush = 1'b0;
  endtask

  always @(posedge clock0) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("dout", 32'(DOUT), 32'(e.dout));
      checkOutput("flags", 32'(dutFlags()), 32'(e.flags));
    end
  end

  initial begin
    logic [31:0] word;
    int          pPush, pPop;
    Async_Flush = 1'b1;
    PUSH        = 1'b0;
    POP         = 1'b0;
    DIN         = '0;
    model_dout  = '0;
    resetFifo();

    for (int k = 0; k < DEPTH; k++) begin
      word = 32'(k) | (32'(k) << 20) | 32'h55000;
      applyStimulus(1'b1, 1'b0, word[DW-1:0]);
    end
    applyStimulus(1'b1, 1'b0, 16'hDEAD);
    applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'(16'hA000 + i));

    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 16'h1234);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 16'($urandom));

    for (int seg = 0; seg < 6; seg++) begin
      pPush = (seg % 2 == 0) ? 75 : 30;
      pPop  = (seg % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 900; i++) begin
        applyStimulus($urandom_range(0, 99) < pPush, $urandom_range(0, 99) < pPop,
                      16'($urandom));
      end
    end

    resetFifo();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'(16'h0B00 + i));
    resetFifo();
    applyStimulus(1'b1, 1'b0, 16'hC0DE);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, '0);

    repeat (3) @(posedge clock0);
    #2;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/af_fifo.md
# af_fifo

Single-clock, first-word-fall-through FIFO with full/empty, almost, watermark and error flags. Parameterised by data width and depth. It covers the 1024x16, 1024x18 and 2048x8 FIFO configurations used on the BRAM18K path. The FIFO holds exactly 2^ADDR_WIDTH words; write and read widths are equal.

## Interface
Parameters:
- DATA_WIDTH, 16: word width; configurations 16 (1024x16), 18 (1024x18), 8 (2048x8).
- ADDR_WIDTH, 10: log2 of depth; 10 for the 1024-deep configurations, 11 for 2048x8. DEPTH = 2^ADDR_WIDTH.
- FULL_WM, DEPTH-4: Full_Watermark threshold.
- EMPTY_WM, 4: Empty_Watermark threshold.

Ports:
- clock0  in  1  sole clock; all state changes on its rising edge.
- Async_Flush  in  1  asynchronous, active-high reset/flush; one clock, reset asynchronous active-high.
- DIN  in  DATA_WIDTH  write data.
- PUSH  in  1  write request.
- POP  in  1  read request.
- DOUT  out  DATA_WIDTH  head-of-FIFO word (first-word-fall-through).
- Full  out  1  count == DEPTH.
- Empty  out  1  count == 0.
- Almost_Full  out  1  count == DEPTH-1.
- Almost_Empty  out  1  count == 1.
- Full_Watermark  out  1  count >= FULL_WM.
- Empty_Watermark  out  1  count <= EMPTY_WM.
- Overrun_Error  out  1  PUSH was rejected on the previous edge.
- Underrun_Error  out  1  POP was rejected on the previous edge.

## Operation
- Storage: DEPTH x DATA_WIDTH memory, wrapping write/read pointers of ADDR_WIDTH bits, occupancy counter of ADDR_WIDTH+1 bits (0..DEPTH).
- Write is accepted when PUSH=1 and (Full=0 or POP is accepted on the same edge). Accepted write stores DIN at the write pointer; the pointer increments modulo DEPTH.
- Read is accepted when POP=1 and Empty=0. Accepted read increments the read pointer modulo DEPTH.
- Counter: +1 on write only, -1 on read only, unchanged on both or neither.
- Rejected PUSH (Full, no accepted POP): data is discarded, no state change, Overrun_Error=1 for the next cycle.
- Rejected POP (Empty): no state change, Underrun_Error=1 for the next cycle. A PUSH on the same edge is still accepted.
- DOUT is first-word-fall-through. Whenever Empty=0, DOUT equals the oldest stored word, with no POP needed to see it. After an accepted POP, DOUT shows the next-oldest word. When Empty=1, DOUT holds its last value.
- All flags are decoded from the registered counter. No combinational path runs from PUSH/POP to flags or DOUT.

## Timing
- Reset (Async_Flush=1, asynchronous):
  - Pointers and counter cleared to 0; memory contents are don't-care.
  - DOUT=0, Empty=1, Empty_Watermark=1.
  - Full, Almost_Full, Almost_Empty, Full_Watermark, Overrun_Error and Underrun_Error all 0.
- Reset release: operation starts at the first rising edge after deassertion. Reset asserted mid-operation discards all contents immediately.
- Write latency: a word pushed at edge N is on DOUT with Empty=0 after edge N, when the FIFO was empty.
- Pop latency: POP sampled at edge N updates DOUT to the next word after edge N.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Full is reached after exactly DEPTH writes with no reads.
- Simultaneous PUSH+POP:
  - When Full: both are accepted; Full stays 1.
  - When Empty: only the write is accepted; Underrun_Error pulses.
  - When count==1: DOUT takes the new word, count stays 1.
- Error flags are single-cycle pulses that re-arm every cycle.

## Test plan
- Reset: assert Async_Flush for 40 ns -> Empty=1, Empty_Watermark=1, all other flags 0, DOUT=0.
- Fill: push words k | (k<<20) | 0x55000, truncated to DATA_WIDTH, for k=0..DEPTH-1 -> Almost_Full at count DEPTH-1; Full=1 after the last push; no Overrun_Error.
- Drain: pop DEPTH times -> before each pop DOUT equals word k in order, with first word 0x55000 masked; Almost_Empty at count 1; Empty=1 at the end.
- Overrun/underrun: push while Full -> Overrun_Error one cycle, contents unchanged. Pop while Empty -> Underrun_Error one cycle.
- Simultaneous push+pop at Full and at count 1 -> count unchanged; FIFO order preserved across pointer wrap.
- Mid-operation flush: assert Async_Flush with 5 words stored -> immediately Empty=1; the next pushed word appears on DOUT after one edge.
